// File: rtl/riscv_pkg.sv
// Shared definitions for the data memory and the load/store bridge:
// access-size encoding, memory FSM states and wait-state limits.
package riscv_pkg;

  typedef enum logic [1:0] {
    Byte_Access     = 2'b00,
    Halfword_Access = 2'b01,
    Reserved_Access = 2'b10,
    Word_Access     = 2'b11
  } mem_access_size_t;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_t;

  localparam int MEM_MAX_WAIT = 15;
  localparam int MEM_WAIT_W   = $clog2(MEM_MAX_WAIT + 1);

  // The reserved size code behaves exactly like a word access.
  function automatic mem_access_size_t effective_size(input mem_access_size_t size);
    return (size == Reserved_Access) ? Word_Access : size;
  endfunction

endpackage

// File: rtl/riscv_data_mem_if.sv
// Request/response bus between the load/store bridge (master) and the
// data memory (slave). Signal names are seen from the memory side.
interface riscv_data_mem_if;

  logic        data_mem_req_i;
  logic [31:0] data_mem_addr_i;
  logic [1:0]  data_mem_byte_en_i;
  logic        data_mem_wr_i;
  logic [31:0] data_mem_wr_data_i;
  logic        mem_ready_o;
  logic        mem_rvalid_o;
  logic [31:0] mem_rd_data_o;
  logic        mem_misaligned_o;

  modport master (
    output data_mem_req_i,
    output data_mem_addr_i,
    output data_mem_byte_en_i,
    output data_mem_wr_i,
    output data_mem_wr_data_i,
    input  mem_ready_o,
    input  mem_rvalid_o,
    input  mem_rd_data_o,
    input  mem_misaligned_o
  );

  modport slave (
    input  data_mem_req_i,
    input  data_mem_addr_i,
    input  data_mem_byte_en_i,
    input  data_mem_wr_i,
    input  data_mem_wr_data_i,
    output mem_ready_o,
    output mem_rvalid_o,
    output mem_rd_data_o,
    output mem_misaligned_o
  );

endinterface

// File: rtl/riscv_mem_lane_steer.sv
// Combinational byte-lane steering: turns size/offset/store data into
// per-byte write strobes and replicated lane data, right-justifies the
// read word, and detects misaligned halfword/word accesses.
module riscv_mem_lane_steer
  import riscv_pkg::*;
(
  input  mem_access_size_t size,
  input  logic [1:0]       offset,
  input  logic [31:0]      wr_data,
  input  logic [31:0]      rd_word,
  output logic [3:0]       strobe,
  output logic [31:0]      lane_data,
  output logic [31:0]      rd_result,
  output logic             misaligned
);

  mem_access_size_t eff_size;
  logic [31:0]      shifted;

  // Decode size and offset; a misaligned access gets no strobes and no data.
  always_comb begin
    eff_size   = effective_size(size);
    shifted    = rd_word >> {offset, 3'b000};
    misaligned = 1'b0;
    strobe     = 4'b0000;
    lane_data  = wr_data;
    rd_result  = '0;
    case (eff_size)
      Byte_Access: begin
        strobe    = 4'b0001 << offset;
        lane_data = {4{wr_data[7:0]}};
        rd_result = {24'h000000, shifted[7:0]};
      end
      Halfword_Access: begin
        misaligned = offset[0];
        strobe     = 4'b0011 << offset;
        lane_data  = {2{wr_data[15:0]}};
        rd_result  = {16'h0000, shifted[15:0]};
      end
      default: begin
        misaligned = (offset != 2'b00);
        strobe     = 4'b1111;
        rd_result  = shifted;
      end
    endcase
    if (misaligned) begin
      strobe    = 4'b0000;
      rd_result = '0;
    end
  end

endmodule

// File: rtl/riscv_data_mem.sv
// Word-organised data memory with one outstanding request, configurable
// wait states, byte/halfword lane steering and misalignment reporting.
// Upper address bits beyond the array are ignored, so the memory aliases.
module riscv_data_mem
  import riscv_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic             clk,
  input logic             reset_n,
  riscv_data_mem_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [MEM_WAIT_W-1:0] WAIT_LOAD  = MEM_WAIT_W'(WAIT_STATES);
  localparam logic [MEM_WAIT_W-1:0] COUNT_ONE  = MEM_WAIT_W'(1);

  mem_state_t            state, next_state;
  logic [MEM_WAIT_W-1:0] count, next_count;

  logic [IDX_W-1:0] lat_idx;
  logic [1:0]       lat_off;
  mem_access_size_t lat_size;
  logic             lat_wr;
  logic [31:0]      lat_data;

  logic             accept, do_access;
  logic [IDX_W-1:0] acc_idx;
  logic [1:0]       acc_off;
  mem_access_size_t acc_size;
  logic             acc_wr;
  logic [31:0]      acc_data;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_word, rd_result, lane_data;
  logic [3:0]  strobe;
  logic        misaligned;
  logic [31:0] rd_data_q;
  logic        misaligned_q;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^bus.data_mem_addr_i[31:IDX_W+2];

  assign accept = bus.data_mem_req_i && (state != MEM_WAIT);

  // With no wait states the access uses the live request on the accept
  // edge; otherwise it uses the latched request when the counter expires.
  always_comb begin
    if (WAIT_STATES == 0) begin
      acc_idx   = bus.data_mem_addr_i[IDX_W+1:2];
      acc_off   = bus.data_mem_addr_i[1:0];
      acc_size  = mem_access_size_t'(bus.data_mem_byte_en_i);
      acc_wr    = bus.data_mem_wr_i;
      acc_data  = bus.data_mem_wr_data_i;
      do_access = accept;
    end else begin
      acc_idx   = lat_idx;
      acc_off   = lat_off;
      acc_size  = lat_size;
      acc_wr    = lat_wr;
      acc_data  = lat_data;
      do_access = (state == MEM_WAIT) && (count == COUNT_ONE);
    end
  end

  riscv_mem_lane_steer u_steer (
    .size       (acc_size),
    .offset     (acc_off),
    .wr_data    (acc_data),
    .rd_word    (rd_word),
    .strobe     (strobe),
    .lane_data  (lane_data),
    .rd_result  (rd_result),
    .misaligned (misaligned)
  );

  assign rd_word = mem[acc_idx];

  // Next-state and wait counter: accept from IDLE or RESP, count down in WAIT.
  always_comb begin
    next_state = state;
    next_count = count;
    case (state)
      MEM_IDLE, MEM_RESP: begin
        if (bus.data_mem_req_i) begin
          if (WAIT_STATES == 0) begin
            next_state = MEM_RESP;
          end else begin
            next_state = MEM_WAIT;
            next_count = WAIT_LOAD;
          end
        end else begin
          next_state = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        next_count = count - COUNT_ONE;
        if (count == COUNT_ONE) begin
          next_state = MEM_RESP;
        end
      end
      default: begin
        next_state = MEM_IDLE;
        next_count = '0;
      end
    endcase
  end

  // State and counter registers; reset abandons any pending access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= MEM_IDLE;
      count <= '0;
    end else begin
      state <= next_state;
      count <= next_count;
    end
  end

  // Capture the request on acceptance for use after the wait states.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lat_idx  <= '0;
      lat_off  <= '0;
      lat_size <= Byte_Access;
      lat_wr   <= 1'b0;
      lat_data <= '0;
    end else if (accept) begin
      lat_idx  <= bus.data_mem_addr_i[IDX_W+1:2];
      lat_off  <= bus.data_mem_addr_i[1:0];
      lat_size <= mem_access_size_t'(bus.data_mem_byte_en_i);
      lat_wr   <= bus.data_mem_wr_i;
      lat_data <= bus.data_mem_wr_data_i;
    end
  end

  // Register the response at the access edge; stores return zero data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q    <= '0;
      misaligned_q <= 1'b0;
    end else if (do_access) begin
      rd_data_q    <= acc_wr ? 32'h0 : rd_result;
      misaligned_q <= misaligned;
    end
  end

  // Byte-strobed write into the storage array; contents are never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (do_access && acc_wr && strobe[b]) begin
        mem[acc_idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  assign bus.mem_ready_o      = (state != MEM_WAIT);
  assign bus.mem_rvalid_o     = (state == MEM_RESP);
  assign bus.mem_rd_data_o    = rd_data_q;
  assign bus.mem_misaligned_o = misaligned_q && (state == MEM_RESP);

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed bench for riscv_data_mem: one instance with no wait states and
// one with three, sharing clock and reset.
module tb_riscv_data_mem;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  riscv_data_mem_if bus_fast ();
  riscv_data_mem_if bus_slow ();

  riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) dut_fast (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_fast)
  );

  riscv_data_mem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) dut_slow (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_slow)
  );

  logic        req_v   [2];
  logic [31:0] addr_v  [2];
  logic [1:0]  size_v  [2];
  logic        wr_v    [2];
  logic [31:0] wdata_v [2];
  logic        ready_w [2];
  logic        rvalid_w[2];
  logic        mis_w   [2];
  logic [31:0] rd_w    [2];

  assign bus_fast.data_mem_req_i     = req_v[0];
  assign bus_fast.data_mem_addr_i    = addr_v[0];
  assign bus_fast.data_mem_byte_en_i = size_v[0];
  assign bus_fast.data_mem_wr_i      = wr_v[0];
  assign bus_fast.data_mem_wr_data_i = wdata_v[0];
  assign ready_w[0]  = bus_fast.mem_ready_o;
  assign rvalid_w[0] = bus_fast.mem_rvalid_o;
  assign mis_w[0]    = bus_fast.mem_misaligned_o;
  assign rd_w[0]     = bus_fast.mem_rd_data_o;

  assign bus_slow.data_mem_req_i     = req_v[1];
  assign bus_slow.data_mem_addr_i    = addr_v[1];
  assign bus_slow.data_mem_byte_en_i = size_v[1];
  assign bus_slow.data_mem_wr_i      = wr_v[1];
  assign bus_slow.data_mem_wr_data_i = wdata_v[1];
  assign ready_w[1]  = bus_slow.mem_ready_o;
  assign rvalid_w[1] = bus_slow.mem_rvalid_o;
  assign mis_w[1]    = bus_slow.mem_misaligned_o;
  assign rd_w[1]     = bus_slow.mem_rd_data_o;

  int check_count = 0;
  int error_count = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Issue one request on a unit, wait for acceptance and the response.
  task automatic applyStimulus(input int unit, input logic wr, input logic [31:0] addr,
                               input logic [1:0] size, input logic [31:0] data,
                               output logic [31:0] rd, output logic mis, output int lat);
    int guard;
    @(negedge clk);
    req_v[unit]   = 1'b1;
    wr_v[unit]    = wr;
    addr_v[unit]  = addr;
    size_v[unit]  = size;
    wdata_v[unit] = data;
    guard = 0;
    while (!ready_w[unit] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) checkOutput("ready_timeout", 32'(ready_w[unit]), 32'h1);
    @(posedge clk);
    @(negedge clk);
    req_v[unit] = 1'b0;
    lat = 1;
    while (!rvalid_w[unit] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd  = rd_w[unit];
    mis = mis_w[unit];
  endtask

  task automatic runAccess(input int unit, input logic wr, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] data,
                           input logic [31:0] exp_rd, input logic exp_mis, input string tag);
    logic [31:0] rd;
    logic        mis;
    int          lat;
    applyStimulus(unit, wr, addr, size, data, rd, mis, lat);
    checkOutput({tag, ":rd"}, rd, exp_rd);
    checkOutput({tag, ":mis"}, 32'(mis), 32'(exp_mis));
    checkOutput({tag, ":lat"}, 32'(lat), (unit == 0) ? 32'd1 : 32'd4);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rvalid_count;
    int guard;
    for (int i = 0; i < 2; i++) begin
      req_v[i]   = 1'b0;
      addr_v[i]  = '0;
      size_v[i]  = 2'b00;
      wr_v[i]    = 1'b0;
      wdata_v[i] = '0;
    end

    // Reset state of both instances
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput($sformatf("reset_ready_u%0d", u), 32'(ready_w[u]), 32'h1);
      checkOutput($sformatf("reset_rvalid_u%0d", u), 32'(rvalid_w[u]), 32'h0);
      checkOutput($sformatf("reset_rd_u%0d", u), rd_w[u], 32'h0);
      checkOutput($sformatf("reset_mis_u%0d", u), 32'(mis_w[u]), 32'h0);
    end
    reset_n = 1'b1;

    // Zero wait states: word, byte and halfword traffic
    runAccess(0, 1'b1, 32'h10, Word_Access, 32'hDEADBEEF, 32'h0, 1'b0, "st_w10");
    runAccess(0, 1'b0, 32'h10, Word_Access, 32'h0, 32'hDEADBEEF, 1'b0, "ld_w10");
    runAccess(0, 1'b1, 32'h10, Word_Access, 32'h11223344, 32'h0, 1'b0, "st_w10b");
    runAccess(0, 1'b1, 32'h13, Byte_Access, 32'h000000A5, 32'h0, 1'b0, "st_b13");
    runAccess(0, 1'b0, 32'h10, Word_Access, 32'h0, 32'hA5223344, 1'b0, "ld_w10_merge");
    runAccess(0, 1'b0, 32'h13, Byte_Access, 32'h0, 32'h000000A5, 1'b0, "ld_b13");
    runAccess(0, 1'b0, 32'h10, Byte_Access, 32'h0, 32'h00000044, 1'b0, "ld_b10");
    runAccess(0, 1'b0, 32'h12, Halfword_Access, 32'h0, 32'h0000A522, 1'b0, "ld_h12");
    runAccess(0, 1'b1, 32'h20, Word_Access, 32'h55667788, 32'h0, 1'b0, "st_w20");
    runAccess(0, 1'b1, 32'h22, Halfword_Access, 32'h0000BEEF, 32'h0, 1'b0, "st_h22");
    runAccess(0, 1'b0, 32'h22, Halfword_Access, 32'h0, 32'h0000BEEF, 1'b0, "ld_h22");
    runAccess(0, 1'b0, 32'h20, Halfword_Access, 32'h0, 32'h00007788, 1'b0, "ld_h20");
    runAccess(0, 1'b0, 32'h21, Halfword_Access, 32'h0, 32'h0, 1'b1, "ld_h21_mis");
    runAccess(0, 1'b1, 32'h21, Halfword_Access, 32'h00001234, 32'h0, 1'b1, "st_h21_mis");
    runAccess(0, 1'b1, 32'h22, Word_Access, 32'hFFFFFFFF, 32'h0, 1'b1, "st_w22_mis");
    runAccess(0, 1'b0, 32'h20, Word_Access, 32'h0, 32'hBEEF7788, 1'b0, "ld_w20_unchanged");
    runAccess(0, 1'b0, 32'h20, Reserved_Access, 32'h0, 32'hBEEF7788, 1'b0, "ld_r20");
    runAccess(0, 1'b0, 32'h22, Reserved_Access, 32'h0, 32'h0, 1'b1, "ld_r22_mis");
    runAccess(0, 1'b1, 32'h00001000, Word_Access, 32'h5A5A1234, 32'h0, 1'b0, "st_alias1000");
    runAccess(0, 1'b0, 32'h00000000, Word_Access, 32'h0, 32'h5A5A1234, 1'b0, "ld_alias0");

    // Three wait states: latency, held request and back-to-back acceptance
    runAccess(1, 1'b1, 32'h40, Word_Access, 32'h13572468, 32'h0, 1'b0, "slow_st40");
    runAccess(1, 1'b1, 32'h44, Word_Access, 32'h0BADF00D, 32'h0, 1'b0, "slow_st44");
    runAccess(1, 1'b0, 32'h45, Byte_Access, 32'h0, 32'h000000F0, 1'b0, "slow_ld_b45");

    @(negedge clk);
    req_v[1]  = 1'b1;
    wr_v[1]   = 1'b0;
    addr_v[1] = 32'h40;
    size_v[1] = Word_Access;
    checkOutput("hold_ready_c0", 32'(ready_w[1]), 32'h1);
    rvalid_count = 0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checkOutput($sformatf("hold_ready_c%0d", c), 32'(ready_w[1]), 32'h0);
      if (rvalid_w[1]) rvalid_count++;
    end
    checkOutput("hold_no_early_rvalid", 32'(rvalid_count), 32'h0);
    @(negedge clk);
    checkOutput("hold_rvalid_c4", 32'(rvalid_w[1]), 32'h1);
    checkOutput("hold_ready_c4", 32'(ready_w[1]), 32'h1);
    checkOutput("hold_rd_c4", rd_w[1], 32'h13572468);
    addr_v[1] = 32'h44;
    @(negedge clk);
    checkOutput("b2b_ready_c5", 32'(ready_w[1]), 32'h0);
    checkOutput("b2b_rvalid_c5", 32'(rvalid_w[1]), 32'h0);
    req_v[1] = 1'b0;
    guard = 0;
    while (!rvalid_w[1] && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_wait", 32'(guard), 32'd3);
    checkOutput("b2b_rd", rd_w[1], 32'h0BADF00D);
    rvalid_count = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rvalid_w[1]) rvalid_count++;
    end
    checkOutput("no_queued_access", 32'(rvalid_count), 32'h0);

    // Reset in the second wait cycle of a store abandons it
    @(negedge clk);
    req_v[1]   = 1'b1;
    wr_v[1]    = 1'b1;
    addr_v[1]  = 32'h40;
    size_v[1]  = Word_Access;
    wdata_v[1] = 32'hCAFEF00D;
    @(negedge clk);
    req_v[1] = 1'b0;
    checkOutput("rst_wait_c1_ready", 32'(ready_w[1]), 32'h0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("rst_ready", 32'(ready_w[1]), 32'h1);
    checkOutput("rst_rvalid", 32'(rvalid_w[1]), 32'h0);
    checkOutput("rst_rd", rd_w[1], 32'h0);
    checkOutput("rst_mis", 32'(mis_w[1]), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rvalid_count = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rvalid_w[1]) rvalid_count++;
    end
    checkOutput("rst_no_response", 32'(rvalid_count), 32'h0);
    runAccess(1, 1'b0, 32'h40, Word_Access, 32'h0, 32'h13572468, 1'b0, "rst_ld40_old");
    runAccess(0, 1'b0, 32'h10, Word_Access, 32'h0, 32'hA5223344, 1'b0, "rst_fast_ld10");

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/riscv_data_mem.md
# riscv_data_mem

Synchronous word-organised data memory behind the load/store bridge. It accepts one request at a time, steers byte/halfword lanes from `data_mem_addr_i[1:0]`, inserts a configurable number of wait states, and returns read data right-justified so the bridge can zero- or sign-extend from bits [7:0] or [15:0]. It flags misaligned accesses instead of performing them.

## Interface
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at least 4.
- `WAIT_STATES`, 0: extra cycles between accept and memory access; range 0..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `data_mem_req_i` in 1: access request.
- `data_mem_addr_i` in 32: byte address.
- `data_mem_byte_en_i` in 2: access size, `riscv_pkg` encoding: Byte_Access=00, Halfword_Access=01, Reserved=10, Word_Access=11.
- `data_mem_wr_i` in 1: 1 = store, 0 = load.
- `data_mem_wr_data_i` in 32: store data, right-justified.
- `mem_ready_o` out 1: request accepted on an edge where `req && ready`.
- `mem_rvalid_o` out 1: one-cycle response pulse; asserted for loads and stores.
- `mem_rd_data_o` out 32: load data, right-justified, upper unused bits zero; valid only while `mem_rvalid_o` is high.
- `mem_misaligned_o` out 1: qualifies `mem_rvalid_o`; the access was dropped.

## Operation
- FSM states:
  - IDLE: `ready`=1.
  - WAIT: `ready`=0; the wait counter is nonzero.
  - RESP: `ready`=1, `rvalid`=1.
- Accept in IDLE or RESP:
  - Latch index, offset, size, write flag and data.
  - If `WAIT_STATES`=0, perform the access on the accept edge and go to RESP.
  - Otherwise load the counter with `WAIT_STATES` and go to WAIT.
- WAIT: decrement each cycle. At the edge where the counter goes 1→0, perform the access and go to RESP.
- RESP with no new request goes to IDLE. RESP with a request accepts it (back-to-back).
- Word index = `addr[$clog2(DEPTH_WORDS)+1:2]`. Upper address bits are ignored and the memory aliases.
- Reserved size is treated as Word_Access.
- Misaligned cases: Halfword with `addr[0]`=1, or Word/Reserved with `addr[1:0]`≠00. For these:
  - No write is performed.
  - `rd_data`=0 and `misaligned`=1 in the RESP cycle.
  - Latency is unchanged.
- Store write strobes (4 bits, one per byte lane):
  - Byte: 0001<<`off`.
  - Half: 0011<<`off`.
  - Word: 1111.
  - Lane data: byte replicated ×4, half replicated ×2, word unchanged.
- Load: the read word is shifted right by 8×`off`, then masked to 8, 16 or 32 bits.
- Store response: `rvalid`=1, `rd_data`=0.
- Memory contents are not reset. Simulation initial content is 0.

## Timing
- Accept at edge E0. The access occurs at edge E0+`WAIT_STATES`. `rvalid` is high in the cycle after that edge, so latency = `WAIT_STATES`+1 cycles.
- Throughput: one access per `WAIT_STATES`+1 cycles.
- Read data is registered; there is no combinational path from inputs to `rd_data`.
- `req` held high while `ready`=0 is ignored and not queued. The requester must hold its request until accepted.
- Reset values: state IDLE, `mem_ready_o`=1, `mem_rvalid_o`=0, `mem_rd_data_o`=0, `mem_misaligned_o`=0, counter=0.
- Reset asserted in WAIT: the pending store is abandoned (memory unchanged) and no response is produced.
- Reset asserted in RESP: the response is cut short.
- A load following a store to the same word sees the stored data; the store committed at least one edge earlier.

## Structure
- `riscv_pkg` holds the access-size enum (shared with the bridge), a `mem_state_t` enum for IDLE/WAIT/RESP, and a `MEM_MAX_WAIT`=15 constant.
- One sub-module: `riscv_mem_lane_steer`, combinational. It maps size, offset and write data to strobes and lane data, maps the read word to a justified result, and outputs the misaligned flag.
- The storage array plus FSM stay in `riscv_data_mem`. The array uses a per-byte-strobe write for RAM inference.

## Test plan
- `WAIT_STATES`=0: store word 0xDEADBEEF at 0x10, then load word at 0x10 → `rvalid` one cycle after each accept, load returns 0xDEADBEEF, `misaligned`=0.
- Byte store 0xA5 at 0x13 over 0x11223344, then word load at 0x10 → 0xA5223344. Byte load at 0x13 → 0x000000A5.
- Halfword store 0xBEEF at 0x22, then half load at 0x22 → 0x0000BEEF. Half load at 0x21 → `misaligned`=1, `rd_data`=0, memory unchanged.
- `WAIT_STATES`=3: accept at cycle 0 → `ready` low in cycles 1–3, `rvalid` in cycle 4. Holding `req` during cycles 1–3 causes no extra accesses. A back-to-back request in cycle 4 is accepted.
- Reset asserted in WAIT cycle 2 of a word store 0xCAFEF00D at 0x40 → outputs go to reset values, a later load at 0x40 returns the old value.
- Aliasing with `DEPTH_WORDS`=1024: store at 0x00001000, then load at 0x00000000 → same word returned.
